// File: rtl/ibex_pkg.sv
// Shared types for the iterative multiply/divide unit.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COMP  = 3'd1,
        FIXUP = 3'd2,
        DONE  = 3'd3
    } md_iter_state_e;

    function automatic logic is_mul(input md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

// File: rtl/ibex_multdiv_iter_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module ibex_multdiv_iter_abs #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = negate ? ({WIDTH{1'b0}} - data) : data;
    end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiplier/divider: shift-add multiply and restoring divide on unsigned
// magnitudes, one bit per cycle, with a one-cycle sign fixup before the result is offered.
module ibex_multdiv_iter
    import ibex_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    md_iter_state_e state_q, state_d;
    md_op_e         op_q;
    logic           sa_q, sb_q;
    logic [WIDTH-1:0] opnd_q, hi_q, lo_q, result_q;
    logic [CW-1:0]    cnt_q;

    logic             accept, special, mul_in;
    logic             sa_in, sb_in, b_zero, div_ovf;
    logic [WIDTH-1:0] a_mag, b_mag, special_res;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi, mul_lo, rem_mask;
    logic               mul_exit;
    logic [CW-1:0]      mul_shamt;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_qbit, comp_last;

    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic               fix_neg;
    logic [WIDTH-1:0]   fix_res;

    ibex_multdiv_iter_abs #(.WIDTH(WIDTH)) u_abs_a (
        .data   (op_a_i),
        .negate (sa_in),
        .result (a_mag)
    );

    ibex_multdiv_iter_abs #(.WIDTH(WIDTH)) u_abs_b (
        .data   (op_b_i),
        .negate (sb_in),
        .result (b_mag)
    );

    ibex_multdiv_iter_abs #(.WIDTH(2 * WIDTH)) u_fix (
        .data   (fix_in),
        .negate (fix_neg),
        .result (fix_out)
    );

    always_comb begin
        sa_in   = op_a_i[WIDTH-1] & signed_mode_i[0];
        sb_in   = op_b_i[WIDTH-1] & signed_mode_i[1];
        mul_in  = ~operator_i[1];
        accept  = in_valid_i & (state_q == IDLE) & ~kill_i;
        b_zero  = (op_b_i == '0);
        div_ovf = signed_mode_i[0] & signed_mode_i[1] & (op_a_i == MIN_VAL) & (op_b_i == '1);
        special = operator_i[1] & (b_zero | div_ovf);
        if (b_zero) begin
            special_res = operator_i[0] ? op_a_i : '1;
        end else begin
            special_res = operator_i[0] ? '0 : MIN_VAL;
        end
    end

    // Multiply: {hi,lo} shifts right, product bits enter lo from the top while the
    // unprocessed multiplier bits sit below them; on early exit the skipped shifts
    // are applied in one go.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
        rem_mask  = ~({WIDTH{1'b1}} << cnt_q);
        mul_exit  = EARLY_EXIT && ((mul_lo & rem_mask) == '0);
        mul_shamt = mul_exit ? cnt_q : '0;
        mul_next  = {mul_hi, mul_lo} >> mul_shamt;

        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_qbit  = ~div_diff[WIDTH];

        comp_last = (cnt_q == '0) || (is_mul(op_q) && mul_exit);
    end

    always_comb begin
        fix_in  = '0;
        fix_neg = sa_q ^ sb_q;
        case (op_q)
            MD_OP_MULL, MD_OP_MULH: fix_in = {hi_q, lo_q};
            MD_OP_DIV:              fix_in = {{WIDTH{1'b0}}, lo_q};
            default: begin
                fix_in  = {{WIDTH{1'b0}}, hi_q};
                fix_neg = sa_q;
            end
        endcase
        fix_res = (op_q == MD_OP_MULH) ? fix_out[2*WIDTH-1:WIDTH] : fix_out[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : COMP;
            COMP:    if (comp_last) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q     <= MD_OP_MULL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q   <= md_op_e'(operator_i);
                        sa_q   <= sa_in;
                        sb_q   <= sb_in;
                        opnd_q <= mul_in ? a_mag : b_mag;
                        lo_q   <= mul_in ? b_mag : a_mag;
                        hi_q   <= '0;
                        cnt_q  <= CNT_INIT;
                        if (special) begin
                            result_q <= special_res;
                        end
                    end
                end
                COMP: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (is_mul(op_q)) begin
                        hi_q <= mul_next[2*WIDTH-1:WIDTH];
                        lo_q <= mul_next[WIDTH-1:0];
                    end else begin
                        hi_q <= div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], div_qbit};
                    end
                end
                FIXUP: result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign result_o    = result_q;

endmodule
